// File: rtl/my_alu_seq.sv
// rtl/my_alu_seq.sv - registered ALU with iterative shifter and one-deep result register (optional ALU_SAT_EN saturation)
module my_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      ir,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic [2:0]       flags,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE_W1 = (WIDTH+1)'(1);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic [2:0]       r_flags;
  logic             r_ill;
  logic             r_valid;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_dir_right;

  logic [3:0]       w_op;
  logic [SHW-1:0]   w_amt;
  logic             w_accept;
  logic             w_is_shift;
  logic             w_shift_done;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;
  logic [WIDTH-1:0] w_work_nxt;
  logic             w_bit_out;
  logic             w_unused_ir;

  // Low instruction bits carry no meaning for this block.
  assign w_unused_ir = ^ir[11:0];

  assign w_op         = ir[15:12];
  assign w_amt        = b[SHW-1:0];
  assign in_ready     = (r_state == S_IDLE) && (!r_valid || out_ready);
  assign w_accept     = in_valid && in_ready;
  assign w_is_shift   = ((w_op == 4'd6) || (w_op == 4'd7)) && (w_amt != '0);
  assign w_shift_done = (r_state == S_SHIFT) && (r_cnt == CNT_ONE);

  // SUB is a + ~b + 1 so the top bit is the no-borrow carry.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} + {1'b0, ~b} + ONE_W1;

  // One step of the iterative shifter and the bit it pushes out.
  assign w_work_nxt = r_dir_right ? (r_work >> 1) : (r_work << 1);
  assign w_bit_out  = r_dir_right ? r_work[0] : r_work[WIDTH-1];

  // Single-cycle result, carry and overflow for the opcode presented now.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (w_op)
      4'd0: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: w_res = a & b;
      4'd3: w_res = a | b;
      4'd4: w_res = a ^ b;
      4'd5: w_res = ~a;
      4'd6, 4'd7: w_res = a;
      default: w_ill = 1'b1;
    endcase
`ifdef ALU_SAT_EN
    // Overflow direction follows the sign of a for both ADD and SUB.
    if (w_v) begin
      w_res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: enter SHIFT on a non-zero shift accept, leave after the last step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_shift) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_ONE) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shifter working register and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work      <= '0;
      r_cnt       <= '0;
      r_dir_right <= 1'b0;
    end else if (w_accept && w_is_shift) begin
      r_work      <= a;
      r_cnt       <= w_amt;
      r_dir_right <= w_op[0];
    end else if (r_state == S_SHIFT) begin
      r_work <= w_work_nxt;
      r_cnt  <= r_cnt - CNT_ONE;
    end
  end

  // Output register: load on single-cycle accept or shift completion, drop on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_flags <= 3'b000;
      r_ill   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept && w_is_shift) begin
      r_ill   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_res   <= w_res;
      r_cout  <= w_c;
      r_flags <= {(w_res == '0), w_res[WIDTH-1], w_v};
      r_ill   <= w_ill;
      r_valid <= 1'b1;
    end else if (w_shift_done) begin
      r_res   <= w_work_nxt;
      r_cout  <= w_bit_out;
      r_flags <= {(w_work_nxt == '0), w_work_nxt[WIDTH-1], 1'b0};
      r_ill   <= 1'b0;
      r_valid <= 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign r         = r_res;
  assign cout      = r_cout;
  assign flags     = r_flags;
  assign illegal   = r_ill;

endmodule
